// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain-side stream reader.
package fifo_pkg;
    localparam int FIFO_WIDTH   = 8;
    localparam int FIFO_PKT_LEN = 4;
    localparam int SKID_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } reader_state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered output buffer; the head entry is always presented.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             I_CLK,
    input  logic             I_RESETN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] entry_reg [SKID_DEPTH];
    logic [WIDTH-1:0] shift_in  [SKID_DEPTH];
    logic [1:0]       occ_reg;
    logic [1:0]       occ_after_pop;

    // Each entry takes its successor on a pop; the tail takes nothing.
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_shift
        if (gi < SKID_DEPTH - 1) begin : g_mid
            assign shift_in[gi] = entry_reg[gi+1];
        end else begin : g_tail
            assign shift_in[gi] = '0;
        end
    end

    assign occ_after_pop = occ_reg - {1'b0, pop};

    always_ff @(posedge I_CLK) begin
        if (!I_RESETN) begin
            occ_reg <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            // A push lands in the first free slot after this cycle's pop.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (push && occ_after_pop == 2'(i)) begin
                    entry_reg[i] <= push_data;
                end else if (pop) begin
                    entry_reg[i] <= shift_in[i];
                end
            end
            occ_reg <= occ_after_pop + {1'b0, push};
        end
    end

    assign occ  = occ_reg;
    assign head = entry_reg[0];
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream with fixed-length
// packet framing and a completed-packet counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int PKT_LEN   = FIFO_PKT_LEN,
    parameter int PKT_CNT_W = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_RESETN,
    input  logic                 I_ENABLE,
    input  logic                 I_FIFO_EMPTY,
    input  logic [WIDTH-1:0]     I_FIFO_DOUT,
    output logic                 O_FIFO_RE,
    output logic                 O_TVALID,
    output logic [WIDTH-1:0]     O_TDATA,
    output logic                 O_TLAST,
    input  logic                 I_TREADY,
    output logic                 O_BUSY,
    output logic [PKT_CNT_W-1:0] O_PKT_CNT
);
    localparam int              BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [1:0]           occ;
    logic [WIDTH-1:0]     head;
    logic                 pop;
    logic [2:0]           level;
    logic                 inflight_reg;
    logic [BEAT_W-1:0]    beat_reg;
    logic [PKT_CNT_W-1:0] pkt_cnt_reg;
    reader_state_t        state_reg;
    reader_state_t        state_next;

    stream_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .I_CLK     (I_CLK),
        .I_RESETN  (I_RESETN),
        .push      (inflight_reg),
        .push_data (I_FIFO_DOUT),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign O_TVALID = (occ != 2'd0);
    assign O_TDATA  = head;
    assign O_TLAST  = O_TVALID && (beat_reg == LAST_BEAT);
    assign pop      = O_TVALID && I_TREADY;

    // Buffer occupancy after this edge; a new read is only issued if it fits.
    assign level     = {1'b0, occ} + {2'b0, inflight_reg} - {2'b0, pop};
    assign O_FIFO_RE = I_RESETN && I_ENABLE && !I_FIFO_EMPTY && (level < 3'd2);

    always_ff @(posedge I_CLK) begin
        if (!I_RESETN) begin
            inflight_reg <= 1'b0;
            beat_reg     <= '0;
            pkt_cnt_reg  <= '0;
            state_reg    <= IDLE;
        end else begin
            inflight_reg <= O_FIFO_RE;
            state_reg    <= state_next;
            if (pop) begin
                beat_reg <= (beat_reg == LAST_BEAT) ? '0 : beat_reg + BEAT_W'(1);
                if (O_TLAST) begin
                    pkt_cnt_reg <= pkt_cnt_reg + PKT_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (O_FIFO_RE) state_next = FILL;
            FILL:    if (inflight_reg) state_next = STREAM;
            STREAM:  if (level == 3'd0) state_next = O_FIFO_RE ? FILL : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign O_BUSY    = (state_reg != IDLE);
    assign O_PKT_CNT = pkt_cnt_reg;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with behavioural FIFO models and a
// per-cycle scoreboard on the stream outputs.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, enable, tready, fifo_empty, fifo_re, tvalid, tlast, busy;
    logic [7:0]  fifo_dout, tdata;
    logic [15:0] pkt_cnt;

    logic        b_enable, b_tready, b_empty, b_re, b_tvalid, b_tlast, b_busy;
    logic [7:0]  b_dout, b_tdata;
    logic [1:0]  b_pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_stream_reader #(.WIDTH(8), .PKT_LEN(4), .PKT_CNT_W(16)) dut (
        .I_CLK(clk), .I_RESETN(resetn), .I_ENABLE(enable), .I_FIFO_EMPTY(fifo_empty),
        .I_FIFO_DOUT(fifo_dout), .O_FIFO_RE(fifo_re), .O_TVALID(tvalid), .O_TDATA(tdata),
        .O_TLAST(tlast), .I_TREADY(tready), .O_BUSY(busy), .O_PKT_CNT(pkt_cnt)
    );

    fifo_stream_reader #(.WIDTH(8), .PKT_LEN(1), .PKT_CNT_W(2)) dut_b (
        .I_CLK(clk), .I_RESETN(resetn), .I_ENABLE(b_enable), .I_FIFO_EMPTY(b_empty),
        .I_FIFO_DOUT(b_dout), .O_FIFO_RE(b_re), .O_TVALID(b_tvalid), .O_TDATA(b_tdata),
        .O_TLAST(b_tlast), .I_TREADY(b_tready), .O_BUSY(b_busy), .O_PKT_CNT(b_pkt_cnt)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Registered-read FIFO models; reset discards unread contents.
    logic [7:0] a_mem [256];
    logic [7:0] a_wr = 8'd0;
    logic [7:0] a_rd = 8'd0;
    logic [7:0] b_mem [256];
    logic [7:0] b_wr = 8'd0;
    logic [7:0] b_rd = 8'd0;

    assign fifo_empty = (a_rd == a_wr);
    assign b_empty    = (b_rd == b_wr);

    always @(posedge clk) begin
        if (!resetn) begin
            a_rd <= a_wr;  fifo_dout <= '0;
            b_rd <= b_wr;  b_dout    <= '0;
        end else begin
            if (fifo_re && !fifo_empty) begin fifo_dout <= a_mem[a_rd]; a_rd <= a_rd + 8'd1; end
            if (b_re && !b_empty) begin b_dout <= b_mem[b_rd]; b_rd <= b_rd + 8'd1; end
        end
    end

    // Scoreboard for the PKT_LEN=4 instance: reads vs. transfers, data order, framing.
    int         cyc = 0;
    int         a_acc = 0, a_xfer = 0, a_beat = 0, a_pkt = 0, outst = 0;
    logic [7:0] a_sb = 8'd0;
    logic       a_inflight = 1'b0, acc_now, pop_now;
    int         re_cyc [$];
    int         x_cyc  [$];
    logic [7:0] x_data [$];
    logic       x_last [$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!resetn) begin
            a_acc = 0; a_xfer = 0; a_beat = 0; a_pkt = 0; a_sb = a_wr; a_inflight = 1'b0;
        end else begin
            outst   = a_acc - a_xfer;
            acc_now = fifo_re && !fifo_empty;
            pop_now = tvalid && tready;
            check_value("busy", busy, outst != 0);
            check_value("tvalid", tvalid, (outst - int'(a_inflight)) != 0);
            check_value("pkt_cnt", pkt_cnt, a_pkt);
            if (fifo_re) check_value("re_while_empty", fifo_empty, 0);
            if (acc_now) begin
                check_value("occ_limit", (outst + 1 - int'(pop_now)) <= 2, 1);
                a_acc++;
                re_cyc.push_back(cyc);
            end
            if (tvalid) begin
                check_value("tdata", tdata, a_mem[a_sb]);
                check_value("tlast", tlast, a_beat == 3);
            end
            if (pop_now) begin
                $display("xfer A cyc=%0d data=%02h last=%0d pkt=%0d", cyc, tdata, tlast, pkt_cnt);
                x_cyc.push_back(cyc); x_data.push_back(tdata); x_last.push_back(tlast);
                if (a_beat == 3) begin a_beat = 0; a_pkt++; end else a_beat++;
                a_sb = a_sb + 8'd1;
                a_xfer++;
            end
            a_inflight = acc_now;
        end
    end

    // Scoreboard for the PKT_LEN=1, 2-bit counter instance.
    logic [7:0] b_sb = 8'd0;
    int         b_nx = 0;
    logic [1:0] b_hist [$];

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            b_sb = b_wr; b_nx = 0;
        end else begin
            check_value("b_pkt_cnt", b_pkt_cnt, b_nx % 4);
            if (b_tvalid) begin
                check_value("b_tlast", b_tlast, 1);
                check_value("b_tdata", b_tdata, b_mem[b_sb]);
            end
            if (b_tvalid && b_tready) begin
                $display("xfer B data=%02h last=%0d pkt=%0d", b_tdata, b_tlast, b_pkt_cnt);
                b_hist.push_back(b_pkt_cnt);
                b_sb = b_sb + 8'd1;
                b_nx++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_a(input logic [7:0] d);
        a_mem[a_wr] = d;
        a_wr = a_wr + 8'd1;
    endtask

    initial begin
        int rb, xb;
        resetn = 1'b0; enable = 1'b0; tready = 1'b0; b_enable = 1'b0; b_tready = 1'b0;
        tick(3);
        check_value("rst_tvalid", tvalid, 0);
        check_value("rst_tdata", tdata, 0);
        check_value("rst_tlast", tlast, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_pkt_cnt", pkt_cnt, 0);
        check_value("rst_fifo_re", fifo_re, 0);
        resetn = 1'b1;

        // Basic drain of 0x01..0x08
        rb = re_cyc.size(); xb = x_cyc.size();
        for (int i = 1; i <= 8; i++) push_a(8'(i));
        enable = 1'b1; tready = 1'b1;
        for (int k = 0; k < 40 && x_cyc.size() < xb + 8; k++) tick();
        tick(3);
        check_value("drain_count", x_cyc.size() - xb, 8);
        if (x_cyc.size() >= xb + 8 && re_cyc.size() > rb) begin
            check_value("drain_latency", x_cyc[xb] - re_cyc[rb], 2);
            check_value("drain_rate", x_cyc[xb+7] - x_cyc[xb], 7);
            for (int i = 0; i < 8; i++) begin
                check_value("drain_data", x_data[xb+i], i + 1);
                check_value("drain_tlast", x_last[xb+i], (i == 3) || (i == 7));
            end
        end
        check_value("drain_pkt_cnt", pkt_cnt, 2);
        check_value("drain_busy", busy, 0);

        // Backpressure, ready pattern 1,0,0,1
        xb = x_cyc.size();
        for (int i = 0; i < 6; i++) push_a(8'h11 + 8'(i));
        for (int k = 0; k < 40; k++) begin
            tready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        tready = 1'b1;
        tick(2);
        check_value("bp_count", x_cyc.size() - xb, 6);
        if (x_cyc.size() >= xb + 6) begin
            for (int i = 0; i < 6; i++) begin
                check_value("bp_data", x_data[xb+i], 8'h11 + i);
                check_value("bp_tlast", x_last[xb+i], i == 3);
            end
        end
        check_value("bp_pkt_cnt", pkt_cnt, 3);

        // Empty FIFO, then a single word
        for (int k = 0; k < 5; k++) begin
            tick();
            check_value("empty_fifo_re", fifo_re, 0);
            check_value("empty_tvalid", tvalid, 0);
            check_value("empty_busy", busy, 0);
        end
        rb = re_cyc.size(); xb = x_cyc.size();
        push_a(8'hA5);
        for (int k = 0; k < 10 && x_cyc.size() == xb; k++) tick();
        check_value("a5_count", x_cyc.size() - xb, 1);
        if (x_cyc.size() > xb && re_cyc.size() > rb) begin
            check_value("a5_latency", x_cyc[xb] - re_cyc[rb], 2);
            check_value("a5_data", x_data[xb], 8'hA5);
        end
        tick(2);

        // Enable drop after two accepted reads
        resetn = 1'b0; enable = 1'b0;
        tick(2);
        check_value("rst2_pkt_cnt", pkt_cnt, 0);
        resetn = 1'b1;
        rb = re_cyc.size(); xb = x_cyc.size();
        for (int i = 0; i < 6; i++) push_a(8'h21 + 8'(i));
        enable = 1'b1;
        for (int k = 0; k < 10 && re_cyc.size() - rb < 2; k++) tick();
        enable = 1'b0;
        tick(8);
        check_value("en_reads", re_cyc.size() - rb, 2);
        check_value("en_words", x_cyc.size() - xb, 2);
        check_value("en_busy", busy, 0);
        if (x_cyc.size() >= xb + 2) begin
            check_value("en_data0", x_data[xb], 8'h21);
            check_value("en_data1", x_data[xb+1], 8'h22);
        end
        enable = 1'b1;
        for (int k = 0; k < 20 && x_cyc.size() - xb < 6; k++) tick();
        tick(2);
        check_value("en_total", x_cyc.size() - xb, 6);
        if (x_cyc.size() >= xb + 6) begin
            for (int i = 0; i < 6; i++) check_value("en_tlast", x_last[xb+i], i == 3);
        end
        check_value("en_pkt_cnt", pkt_cnt, 1);

        // Reset with the buffer full
        tready = 1'b0;
        for (int i = 0; i < 6; i++) push_a(8'h31 + 8'(i));
        tick(5);
        check_value("mid_tvalid", tvalid, 1);
        check_value("mid_busy", busy, 1);
        check_value("mid_fifo_re", fifo_re, 0);
        check_value("mid_tdata", tdata, 8'h31);
        resetn = 1'b0;
        tick();
        check_value("mid_rst_tvalid", tvalid, 0);
        check_value("mid_rst_tdata", tdata, 0);
        check_value("mid_rst_tlast", tlast, 0);
        check_value("mid_rst_busy", busy, 0);
        check_value("mid_rst_pkt_cnt", pkt_cnt, 0);
        check_value("mid_rst_fifo_re", fifo_re, 0);
        resetn = 1'b1; tready = 1'b1;
        xb = x_cyc.size();
        tick(6);
        check_value("no_stale", x_cyc.size() - xb, 0);
        check_value("post_rst_tvalid", tvalid, 0);

        // PKT_LEN=1 with a 2-bit packet counter
        for (int i = 0; i < 5; i++) begin
            b_mem[b_wr] = 8'h41 + 8'(i);
            b_wr = b_wr + 8'd1;
        end
        b_enable = 1'b1; b_tready = 1'b1;
        for (int k = 0; k < 20 && b_nx < 5; k++) tick();
        tick(2);
        check_value("b_words", b_nx, 5);
        check_value("b_pkt_final", b_pkt_cnt, 1);
        if (b_hist.size() >= 5) begin
            check_value("b_pkt_after3", b_hist[3], 3);
            check_value("b_pkt_after4", b_hist[4], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
